// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the multi-cycle multiply/divide sequencer.
//   MD_DATA_W      operand width (the add/sub datapath is fixed at 8 bits)
//   ST_IDLE/RUN/DONE  sequencer state encoding
//   OP_MUL/OP_DIV  op select encoding
//   DIV0_QUOT      quotient reported on divide by zero
//   muldiv_res_t   completed-operation payload {err, hi, lo}
package muldiv_pkg;

    localparam int unsigned MD_DATA_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [MD_DATA_W-1:0] DIV0_QUOT = 8'hFF;

    typedef struct packed {
        logic                 err;
        logic [MD_DATA_W-1:0] hi;
        logic [MD_DATA_W-1:0] lo;
    } muldiv_res_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done request bus between CPU control and the sequencer.
//   master (CPU side): drives start, op, a, b; observes busy, done, result_hi, result_lo, err
//   slave  (sequencer): the reverse
interface muldiv_if;
    import muldiv_pkg::*;

    logic                 start;
    logic                 op;
    logic [MD_DATA_W-1:0] a;
    logic [MD_DATA_W-1:0] b;
    logic                 busy;
    logic                 done;
    logic [MD_DATA_W-1:0] result_hi;
    logic [MD_DATA_W-1:0] result_lo;
    logic                 err;

    modport master (
        output start, op, a, b,
        input  busy, done, result_hi, result_lo, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_hi, result_lo, err
    );

endinterface

// File: rtl/addsub8.sv
// addsub8: combinational 8-bit adder/subtractor, {o_carry_c, o_sum_c} = i_a + (i_b ^ {8{i_sub}}) + i_sub.
//   i_a, i_b   operands
//   i_sub      1 = subtract (carry out of 1 means no borrow)
//   o_sum_c    8-bit result
//   o_carry_c  carry out (9th bit)
module addsub8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_sub,
    output logic [7:0] o_sum_c,
    output logic       o_carry_c
);

    logic [7:0] w_b_eff;

    assign w_b_eff = i_b ^ {8{i_sub}};
    assign {o_carry_c, o_sum_c} = 9'(i_a) + 9'(w_b_eff) + 9'(i_sub);

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned 8x8 shift-add multiply and 8/8 restoring divide,
// one add/sub per clock through a shared addsub8, fixed latency start/busy/done handshake.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  start/op/a/b in; busy/done/result_hi/result_lo/err out
// Build option: define MULDIV_DIV_EN to include the divide path; without it, a divide
// request completes one cycle after accept with zero results and err set.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = MD_DATA_W,
    parameter int unsigned ITER   = DATA_W
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    // Width is tied to the 8-bit add/sub datapath.
    generate
        if (DATA_W != 8) begin : g_bad_width
            $error("muldiv_seq: DATA_W must be 8");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_acc;      // mul: accumulator, div: remainder
    logic [DATA_W-1:0] r_mq;       // mul: multiplier/product low, div: dividend/quotient
    logic [DATA_W-1:0] r_b;
    logic              r_short;    // completes after a single RUN cycle (error path)
    logic              r_busy;
    logic              r_done;
    muldiv_res_t       r_res;
`ifdef MULDIV_DIV_EN
    logic              r_op;
`endif

    logic              w_accept;
    logic              w_finish;
    logic              w_short_req;
    logic [DATA_W-1:0] w_as_a;
    logic              w_as_sub;
    logic [DATA_W-1:0] w_sum;
    logic              w_carry;
    logic [DATA_W-1:0] w_acc_it;
    logic [DATA_W-1:0] w_mq_it;

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_finish = (r_state == ST_RUN) && (w_state_nxt == ST_DONE);

`ifdef MULDIV_DIV_EN
    assign w_short_req = (bus.op == OP_DIV) && (bus.b == '0);
`else
    assign w_short_req = (bus.op == OP_DIV);
`endif

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_short || (r_cnt == CNT_W'(ITER - 1))) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Add/sub operand select: divide feeds the left-shifted remainder and subtracts
    always_comb begin
        w_as_a   = r_acc;
        w_as_sub = 1'b0;
`ifdef MULDIV_DIV_EN
        if (r_op == OP_DIV) begin
            w_as_a   = {r_acc[DATA_W-2:0], r_mq[DATA_W-1]};
            w_as_sub = 1'b1;
        end
`endif
    end

    addsub8 u_addsub (
        .i_a       (w_as_a),
        .i_b       (r_b),
        .i_sub     (w_as_sub),
        .o_sum_c   (w_sum),
        .o_carry_c (w_carry)
    );

    // One iteration of the selected algorithm
    always_comb begin
        w_acc_it = r_acc;
        w_mq_it  = r_mq;
`ifdef MULDIV_DIV_EN
        if (r_op == OP_DIV) begin
            // msb shifted out of rem[7] means the shifted remainder already exceeds b
            if (r_acc[DATA_W-1] | w_carry) begin
                w_acc_it = w_sum;
                w_mq_it  = {r_mq[DATA_W-2:0], 1'b1};
            end else begin
                w_acc_it = w_as_a;
                w_mq_it  = {r_mq[DATA_W-2:0], 1'b0};
            end
        end else
`endif
        begin
            if (r_mq[0]) {w_acc_it, w_mq_it} = {w_carry, w_sum, r_mq[DATA_W-1:1]};
            else         {w_acc_it, w_mq_it} = {1'b0, r_acc, r_mq[DATA_W-1:1]};
        end
    end

    // Working registers, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_b     <= '0;
            r_short <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
`ifdef MULDIV_DIV_EN
            r_op    <= OP_MUL;
`endif
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_cnt     <= '0;
                r_acc     <= '0;
                r_mq      <= bus.a;
                r_b       <= bus.b;
                r_short   <= w_short_req;
                r_res.err <= 1'b0;
`ifdef MULDIV_DIV_EN
                r_op      <= bus.op;
`endif
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (!r_short) begin
                    r_acc <= w_acc_it;
                    r_mq  <= w_mq_it;
                end
            end
            if (w_finish) begin
                if (r_short) begin
`ifdef MULDIV_DIV_EN
                    r_res <= '{err: 1'b1, hi: r_mq, lo: DIV0_QUOT};
`else
                    r_res <= '{err: 1'b1, hi: '0, lo: '0};
`endif
                end else begin
                    r_res <= '{err: 1'b0, hi: w_acc_it, lo: w_mq_it};
                end
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result_hi = r_res.hi;
    assign bus.result_lo = r_res.lo;
    assign bus.err       = r_res.err;

endmodule
